// File: rtl/alu_sequencer.sv
// Sequences LOAD/EXEC/READ instructions onto a register-file/ALU datapath and returns one response per instruction.
// Optional performance counters are enabled by defining ALU_SEQ_PERF_EN.
module alu_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [WIDTH+7:0]   instr,
   output logic [WIDTH-1:0]   dp_data_in,
   output logic [1:0]         dp_reg_sel,
   output logic [2:0]         dp_alu_op,
   output logic               dp_write_en,
   output logic               dp_alu_en,
   output logic               dp_cin,
   input  logic [WIDTH-1:0]   dp_data_out,
   input  logic               dp_zero,
   input  logic               dp_neg,
   input  logic               dp_ovf,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WIDTH-1:0]   rsp_data,
   output logic [2:0]         rsp_flags,
   output logic               rsp_err,
   output logic [15:0]        op_count,
   output logic [15:0]        err_count
);

   localparam int unsigned IW = WIDTH + 8;
   localparam logic [1:0] KIND_LOAD = 2'b00;
   localparam logic [1:0] KIND_EXEC = 2'b01;
   localparam logic [1:0] KIND_BAD  = 2'b11;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   state_t            state, state_d;
   logic [IW-1:0]     instr_q, instr_q_d, cur;
   logic [2:0]        flags_q, flags_d;

   logic [1:0]        kind, rd;
   logic [2:0]        op;
   logic              cin;
   logic [WIDTH-1:0]  imm;
   logic              illegal, is_write, is_exec, accept, hs;

   logic              instr_ready_d, dp_write_en_d, dp_alu_en_d, dp_cin_d;
   logic [WIDTH-1:0]  dp_data_in_d, rsp_data_d;
   logic [1:0]        dp_reg_sel_d;
   logic [2:0]        dp_alu_op_d, rsp_flags_d;
   logic              rsp_valid_d, rsp_err_d;

   // Decode the incoming word while idle, the held word otherwise
   always_comb begin
      cur      = (state == IDLE) ? instr : instr_q;
      kind     = cur[WIDTH+7:WIDTH+6];
      rd       = cur[WIDTH+5:WIDTH+4];
      op       = cur[WIDTH+3:WIDTH+1];
      cin      = cur[WIDTH];
      imm      = cur[WIDTH-1:0];
      illegal  = (kind == KIND_BAD) || (rd == 2'b11);
      is_exec  = !illegal && (kind == KIND_EXEC);
      is_write = !illegal && ((kind == KIND_LOAD) || (kind == KIND_EXEC));
      accept   = instr_valid && instr_ready;
      hs       = rsp_valid && rsp_ready;
   end

   // Next state plus next values of every registered output
   always_comb begin
      state_d       = state;
      instr_q_d     = instr_q;
      flags_d       = flags_q;
      rsp_data_d    = rsp_data;
      rsp_flags_d   = rsp_flags;
      rsp_err_d     = rsp_err;
      dp_data_in_d  = '0;
      dp_reg_sel_d  = '0;
      dp_alu_op_d   = '0;
      dp_write_en_d = 1'b0;
      dp_alu_en_d   = 1'b0;
      dp_cin_d      = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               state_d   = ISSUE;
               instr_q_d = instr;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
            flags_d = is_exec ? {dp_ovf, dp_neg, dp_zero} : 3'b000;
         end
         CAPTURE: begin
            state_d     = RESP;
            rsp_data_d  = illegal ? '0 : dp_data_out;
            rsp_flags_d = flags_q;
            rsp_err_d   = illegal;
         end
         RESP: begin
            if (hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Controls are registered, so they are derived from the state being entered
      case (state_d)
         ISSUE: begin
            dp_reg_sel_d = rd;
            if (is_write) begin
               dp_write_en_d = 1'b1;
               dp_data_in_d  = imm;
               if (is_exec) begin
                  dp_alu_en_d = 1'b1;
                  dp_alu_op_d = op;
                  dp_cin_d    = cin;
               end
            end
         end
         CAPTURE: dp_reg_sel_d = rd;
         default: ;
      endcase

      instr_ready_d = (state_d == IDLE);
      // One bubble cycle in RESP before the response is offered
      rsp_valid_d   = (state == RESP) && !hs;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         instr_q     <= '0;
         flags_q     <= '0;
         instr_ready <= 1'b0;
         dp_data_in  <= '0;
         dp_reg_sel  <= '0;
         dp_alu_op   <= '0;
         dp_write_en <= 1'b0;
         dp_alu_en   <= 1'b0;
         dp_cin      <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_flags   <= '0;
         rsp_err     <= 1'b0;
      end else begin
         state       <= state_d;
         instr_q     <= instr_q_d;
         flags_q     <= flags_d;
         instr_ready <= instr_ready_d;
         dp_data_in  <= dp_data_in_d;
         dp_reg_sel  <= dp_reg_sel_d;
         dp_alu_op   <= dp_alu_op_d;
         dp_write_en <= dp_write_en_d;
         dp_alu_en   <= dp_alu_en_d;
         dp_cin      <= dp_cin_d;
         rsp_valid   <= rsp_valid_d;
         rsp_data    <= rsp_data_d;
         rsp_flags   <= rsp_flags_d;
         rsp_err     <= rsp_err_d;
      end
   end

`ifdef ALU_SEQ_PERF_EN
   logic [15:0] op_cnt_q, err_cnt_q;

   // Counters advance on response handshakes and wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else if (hs) begin
         op_cnt_q <= op_cnt_q + 16'd1;
         if (rsp_err) err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign op_count  = op_cnt_q;
   assign err_count = err_cnt_q;
`else
   assign op_count  = 16'd0;
   assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 4-register/ALU datapath attached.
// Define ALU_SEQ_PERF_EN at compile time to also check the performance counters.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid, instr_ready;
   logic [15:0] instr;
   logic [7:0]  dp_data_in, dp_data_out, rsp_data;
   logic [1:0]  dp_reg_sel;
   logic [2:0]  dp_alu_op, rsp_flags;
   logic        dp_write_en, dp_alu_en, dp_cin, dp_zero, dp_neg, dp_ovf;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [15:0] op_count, err_count;

   alu_sequencer #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .dp_data_in(dp_data_in), .dp_reg_sel(dp_reg_sel), .dp_alu_op(dp_alu_op),
      .dp_write_en(dp_write_en), .dp_alu_en(dp_alu_en), .dp_cin(dp_cin),
      .dp_data_out(dp_data_out), .dp_zero(dp_zero), .dp_neg(dp_neg), .dp_ovf(dp_ovf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_flags(rsp_flags), .rsp_err(rsp_err),
      .op_count(op_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Datapath: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; second operand is always r2
   logic [7:0] r [4];
   logic [7:0] alu_res;
   logic       alu_ovf;
   int         wr_cnt = 0;

   always_comb begin
      alu_res = dp_data_in;
      alu_ovf = 1'b0;
      if (dp_alu_en) begin
         case (dp_alu_op)
            3'd0: begin
               alu_res = dp_data_in + r[2] + {7'd0, dp_cin};
               alu_ovf = (dp_data_in[7] == r[2][7]) && (alu_res[7] != dp_data_in[7]);
            end
            3'd1: begin
               alu_res = dp_data_in - r[2] - {7'd0, dp_cin};
               alu_ovf = (dp_data_in[7] != r[2][7]) && (alu_res[7] != dp_data_in[7]);
            end
            3'd2: alu_res = dp_data_in & r[2];
            3'd3: alu_res = dp_data_in | r[2];
            3'd4: alu_res = dp_data_in ^ r[2];
            default: alu_res = dp_data_in;
         endcase
      end
   end

   assign dp_zero     = (alu_res == 8'd0);
   assign dp_neg      = alu_res[7];
   assign dp_ovf      = alu_ovf;
   assign dp_data_out = r[dp_reg_sel];

   always @(posedge clk) begin
      if (dp_write_en) begin
         r[dp_reg_sel] <= alu_res;
         wr_cnt        <= wr_cnt + 1;
      end
   end

   typedef struct {
      string      name;
      logic [1:0] kind;
      logic [1:0] rd;
      logic [2:0] op;
      logic       cin;
      logic [7:0] imm;
      logic [7:0] exp_data;
      logic [2:0] exp_flags;
      logic       exp_err;
      int         exp_wr;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_ops = 0;
   int   exp_errs = 0;

   function automatic vec_t mk(string n, logic [1:0] k, logic [1:0] rd, logic [2:0] op,
                               logic c, logic [7:0] imm, logic [7:0] d, logic [2:0] f,
                               logic e, int w);
      vec_t v;
      v.name = n; v.kind = k; v.rd = rd; v.op = op; v.cin = c; v.imm = imm;
      v.exp_data = d; v.exp_flags = f; v.exp_err = e; v.exp_wr = w;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {2'b00, instr_ready, rsp_valid, rsp_data, rsp_flags, rsp_err, dp_data_in,
              dp_reg_sel, dp_alu_op, dp_write_en, dp_alu_en, dp_cin, op_count, err_count};
   endfunction

   task automatic check_perf(input string tag);
`ifdef ALU_SEQ_PERF_EN
      check({tag, " op_count"}, 64'(op_count), 64'(exp_ops));
      check({tag, " err_count"}, 64'(err_count), 64'(exp_errs));
`else
      check({tag, " op_count"}, 64'(op_count), 64'd0);
      check({tag, " err_count"}, 64'(err_count), 64'd0);
`endif
   endtask

   // Offer one instruction and run up to the first cycle with rsp_valid high
   task automatic start_instr(input vec_t v, output int base_wr);
      int w, lat;
      logic busy_ready;
      logic wr;
      w = 0;
      while (!instr_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      check({v.name, " ready before issue"}, 64'(instr_ready), 64'd1);
      base_wr     = wr_cnt;
      instr       = {v.kind, v.rd, v.op, v.cin, v.imm};
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      wr = (v.exp_wr != 0);
      check({v.name, " issue write_en"}, 64'(dp_write_en), 64'(wr));
      if (wr)
         check({v.name, " issue controls"},
               64'({dp_alu_en, dp_reg_sel, dp_data_in, dp_alu_op, dp_cin}),
               64'({(v.kind == 2'b01), v.rd, v.imm,
                    (v.kind == 2'b01) ? v.op : 3'd0, (v.kind == 2'b01) ? v.cin : 1'b0}));
      lat = 0;
      busy_ready = 1'b0;
      while (!rsp_valid && lat < 20) begin
         if (instr_ready) busy_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      check({v.name, " latency"}, 64'(lat), 64'd3);
      check({v.name, " ready while busy"}, 64'(busy_ready), 64'd0);
      check({v.name, " rsp_data"}, 64'(rsp_data), 64'(v.exp_data));
      check({v.name, " rsp_flags"}, 64'(rsp_flags), 64'(v.exp_flags));
      check({v.name, " rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
      check({v.name, " dp idle in resp"},
            64'({dp_data_in, dp_reg_sel, dp_alu_op, dp_write_en, dp_alu_en, dp_cin}), 64'd0);
   endtask

   task automatic finish_instr(input vec_t v, input int base_wr);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      exp_ops++;
      if (v.exp_err) exp_errs++;
      check({v.name, " post handshake"}, 64'({rsp_valid, instr_ready}), 64'b01);
      check({v.name, " write pulses"}, 64'(wr_cnt - base_wr), 64'(v.exp_wr));
   endtask

   task automatic run_instr(input vec_t v);
      int b;
      start_instr(v, b);
      finish_instr(v, b);
   endtask

   initial begin
      vec_t v;
      int   b;
      logic [7:0] held;

      rst_n = 1'b0; instr_valid = 1'b0; rsp_ready = 1'b0; instr = '0;

      // Kinds: 0 LOAD, 1 EXEC, 2 READ, 3 illegal
      vq.push_back(mk("load r2=03",      2'd0, 2'd2, 3'd0, 1'b0, 8'h03, 8'h03, 3'b000, 1'b0, 1));
      vq.push_back(mk("add r0 05",       2'd1, 2'd0, 3'd0, 1'b0, 8'h05, 8'h08, 3'b000, 1'b0, 1));
      vq.push_back(mk("sub r1 03 zero",  2'd1, 2'd1, 3'd1, 1'b0, 8'h03, 8'h00, 3'b001, 1'b0, 1));
      vq.push_back(mk("read r1",         2'd2, 2'd1, 3'd0, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 0));
      vq.push_back(mk("read r0",         2'd2, 2'd0, 3'd0, 1'b0, 8'h00, 8'h08, 3'b000, 1'b0, 0));
      vq.push_back(mk("add r0 cin",      2'd1, 2'd0, 3'd0, 1'b1, 8'h05, 8'h09, 3'b000, 1'b0, 1));
      vq.push_back(mk("and r1 0f",       2'd1, 2'd1, 3'd2, 1'b0, 8'h0F, 8'h03, 3'b000, 1'b0, 1));
      vq.push_back(mk("xor r0 zero",     2'd1, 2'd0, 3'd4, 1'b0, 8'h03, 8'h00, 3'b001, 1'b0, 1));
      vq.push_back(mk("load r2=01",      2'd0, 2'd2, 3'd0, 1'b0, 8'h01, 8'h01, 3'b000, 1'b0, 1));
      vq.push_back(mk("add ovf neg",     2'd1, 2'd0, 3'd0, 1'b0, 8'h7F, 8'h80, 3'b110, 1'b0, 1));
      vq.push_back(mk("illegal kind",    2'd3, 2'd0, 3'd0, 1'b0, 8'h55, 8'h00, 3'b000, 1'b1, 0));
      vq.push_back(mk("illegal rd",      2'd0, 2'd3, 3'd0, 1'b0, 8'h77, 8'h00, 3'b000, 1'b1, 0));
      vq.push_back(mk("sub r1 neg",      2'd1, 2'd1, 3'd1, 1'b0, 8'h00, 8'hFF, 3'b010, 1'b0, 1));
      vq.push_back(mk("or r2 self",      2'd1, 2'd2, 3'd3, 1'b0, 8'h80, 8'h81, 3'b010, 1'b0, 1));
      vq.push_back(mk("read r2",         2'd2, 2'd2, 3'd0, 1'b0, 8'h00, 8'h81, 3'b000, 1'b0, 0));
      vq.push_back(mk("load r2=01 b",    2'd0, 2'd2, 3'd0, 1'b0, 8'h01, 8'h01, 3'b000, 1'b0, 1));
      vq.push_back(mk("sub ovf",         2'd1, 2'd1, 3'd1, 1'b0, 8'h80, 8'h7F, 3'b100, 1'b0, 1));
      vq.push_back(mk("read r0 kept",    2'd2, 2'd0, 3'd0, 1'b0, 8'h00, 8'h80, 3'b000, 1'b0, 0));
      vq.push_back(mk("sub cin",         2'd1, 2'd0, 3'd1, 1'b1, 8'h05, 8'h03, 3'b000, 1'b0, 1));

      #2;
      check("reset outputs", all_outs(), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ready before first edge", 64'(instr_ready), 64'd0);
      @(negedge clk);
      check("ready after first edge", 64'(instr_ready), 64'd1);

      foreach (vq[i]) run_instr(vq[i]);
      check_perf("after table");

      // Back-pressure: hold rsp_ready low while a competing LOAD is offered
      v = mk("stall read r1", 2'd2, 2'd1, 3'd0, 1'b0, 8'h00, 8'h7F, 3'b000, 1'b0, 0);
      start_instr(v, b);
      held = rsp_data;
      instr = {2'd0, 2'd1, 3'd0, 1'b0, 8'hEE};
      instr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("stall hold", 64'({rsp_valid, instr_ready, rsp_data, rsp_flags, rsp_err}),
               64'({1'b1, 1'b0, held, 3'b000, 1'b0}));
      end
      instr_valid = 1'b0;
      finish_instr(v, b);
      run_instr(mk("read r1 after stall", 2'd2, 2'd1, 3'd0, 1'b0, 8'h00, 8'h7F, 3'b000, 1'b0, 0));
      check_perf("after stall");

      // Abort mid-instruction: assert reset while in CAPTURE
      instr = {2'd0, 2'd0, 3'd0, 1'b0, 8'h11};
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      b = wr_cnt;
      rst_n = 1'b0;
      #1;
      check("abort outputs zero", all_outs(), 64'd0);
      exp_ops = 0;
      exp_errs = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no response after abort", 64'(rsp_valid), 64'd0);
      end
      check("no write after abort", 64'(wr_cnt - b), 64'd0);
      run_instr(mk("load r0=a5", 2'd0, 2'd0, 3'd0, 1'b0, 8'hA5, 8'hA5, 3'b000, 1'b0, 1));
      run_instr(mk("read r0=a5", 2'd2, 2'd0, 3'd0, 1'b0, 8'h00, 8'hA5, 3'b000, 1'b0, 0));
      check_perf("after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
